// File: rtl/sd_block_read_if.sv
// Request, SPI pin and byte-stream signals of the SD single-block read stage.
// master = requester/card side, slave = the read stage itself.
interface sd_block_read_if;
    logic        start;
    logic [31:0] addr;
    logic        miso;
    logic        sclk;
    logic        mosi;
    logic        cs;
    logic [7:0]  data;
    logic        valid;
    logic        busy;
    logic        done;
    logic        err;

    modport master (
        output start, addr, miso,
        input  sclk, mosi, cs, data, valid, busy, done, err
    );

    modport slave (
        input  start, addr, miso,
        output sclk, mosi, cs, data, valid, busy, done, err
    );
endinterface

// File: rtl/sd_block_read.sv
// SD single-block read (CMD17) over SPI mode 0 with its own bit engine.
// Streams the data block as valid-strobed bytes, drops the CRC.
module sd_block_read #(
    parameter int CLK_DIV       = 2,
    parameter int R1_TIMEOUT    = 8,
    parameter int TOKEN_TIMEOUT = 4096,
    parameter int BLOCK_BYTES   = 512
) (
    input logic        i_clk,
    input logic        i_rst,
    sd_block_read_if.slave bus
);

    localparam int MAX_A   = (TOKEN_TIMEOUT > BLOCK_BYTES)
                           ? TOKEN_TIMEOUT : BLOCK_BYTES;
    localparam int MAX_B   = (R1_TIMEOUT > 8) ? R1_TIMEOUT : 8;
    localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW      = $clog2(CNT_MAX);
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] R1_LAST  = CW'(R1_TIMEOUT - 1);
    localparam logic [CW-1:0] TOK_LAST = CW'(TOKEN_TIMEOUT - 1);
    localparam logic [CW-1:0] BLK_LAST = CW'(BLOCK_BYTES - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_PRE,
        S_CMD,
        S_R1,
        S_TOKEN,
        S_DATA,
        S_CRC,
        S_TAIL,
        S_FIN
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_q, err_d;
    logic [31:0]     addr_q;

    logic [DW-1:0]   div_q;
    logic [3:0]      half_q;
    logic            sclk_q;
    logic            mosi_q;
    logic [7:0]      tx_q, tx_d;
    logic [7:0]      rx_q;
    logic [7:0]      data_q;
    logic            valid_q;

    logic run;
    logic tick;
    logic rise;
    logic last_rise;
    logic byte_end;
    logic accept;

    assign run       = (state_q != S_IDLE) && (state_q != S_FIN);
    assign tick      = run && (div_q == DIV_LAST);
    assign rise      = tick && !half_q[0];
    assign last_rise = tick && (half_q == 4'd14);
    assign byte_end  = tick && (half_q == 4'd15);
    assign accept    = (state_q == S_IDLE) && bus.start;

    // Decisions are taken at the end of each byte; rx_q then holds
    // the complete byte just clocked in and tx_d is the next byte out.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        tx_d    = 8'hFF;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_PRE;
                    err_d   = 1'b0;
                end
            end
            S_PRE: begin
                if (byte_end) begin
                    state_d = S_CMD;
                    cnt_d   = '0;
                    tx_d    = 8'h51;
                end
            end
            S_CMD: begin
                if (byte_end) begin
                    if (cnt_q == CW'(5)) begin
                        state_d = S_R1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        unique case (cnt_q[2:0])
                            3'd0:    tx_d = addr_q[31:24];
                            3'd1:    tx_d = addr_q[23:16];
                            3'd2:    tx_d = addr_q[15:8];
                            3'd3:    tx_d = addr_q[7:0];
                            default: tx_d = 8'hFF;
                        endcase
                    end
                end
            end
            S_R1: begin
                if (byte_end) begin
                    if (!rx_q[7]) begin
                        if (rx_q == 8'h00) begin
                            state_d = S_TOKEN;
                            cnt_d   = '0;
                        end else begin
                            state_d = S_TAIL;
                            err_d   = 1'b1;
                        end
                    end else if (cnt_q == R1_LAST) begin
                        state_d = S_TAIL;
                        err_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_TOKEN: begin
                if (byte_end) begin
                    if (rx_q == 8'hFE) begin
                        state_d = S_DATA;
                        cnt_d   = '0;
                    end else if (rx_q != 8'hFF) begin
                        state_d = S_TAIL;
                        err_d   = 1'b1;
                    end else if (cnt_q == TOK_LAST) begin
                        state_d = S_TAIL;
                        err_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (byte_end) begin
                    if (cnt_q == BLK_LAST) begin
                        state_d = S_CRC;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_CRC: begin
                if (byte_end) begin
                    if (cnt_q == CW'(1)) begin
                        state_d = S_TAIL;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_TAIL: begin
                if (byte_end) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            if (accept) begin
                addr_q <= bus.addr;
            end
        end
    end

    // half_q walks 16 SCLK half-periods per byte: even = low, odd = high.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            div_q   <= '0;
            half_q  <= '0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b1;
            tx_q    <= 8'hFF;
            rx_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (!run) begin
                div_q  <= '0;
                half_q <= '0;
                sclk_q <= 1'b0;
                mosi_q <= 1'b1;
                tx_q   <= 8'hFF;
            end else begin
                div_q <= tick ? '0 : div_q + 1'b1;
                if (tick) begin
                    half_q <= half_q + 4'd1;
                    sclk_q <= ~half_q[0];
                end
                if (rise) begin
                    rx_q <= {rx_q[6:0], bus.miso};
                end
                if (last_rise && (state_q == S_DATA)) begin
                    data_q  <= {rx_q[6:0], bus.miso};
                    valid_q <= 1'b1;
                end
                if (byte_end) begin
                    tx_q   <= tx_d;
                    mosi_q <= tx_d[7];
                end else if (tick && half_q[0]) begin
                    tx_q   <= {tx_q[6:0], 1'b1};
                    mosi_q <= tx_q[6];
                end
            end
        end
    end

    assign bus.sclk  = sclk_q;
    assign bus.mosi  = mosi_q;
    assign bus.cs    = !(state_q inside {S_CMD, S_R1, S_TOKEN,
                                         S_DATA, S_CRC});
    assign bus.data  = data_q;
    assign bus.valid = valid_q;
    assign bus.busy  = run;
    assign bus.done  = (state_q == S_FIN);
    assign bus.err   = (state_q == S_FIN) && err_q;

endmodule

// File: tb/tb_sd_block_read.sv
// Bench for sd_block_read: byte-level SD card model on the SPI pins,
// expected stream and poll counts derived from the read protocol.
module tb_sd_block_read;

    localparam int CLK_DIV = 2;
    localparam int R1_TO   = 8;
    localparam int TOK_TO  = 64;
    localparam int BLK     = 512;
    localparam int BYTE_CY = 16 * CLK_DIV;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sd_block_read_if bus();

    sd_block_read #(
        .CLK_DIV      (CLK_DIV),
        .R1_TIMEOUT   (R1_TO),
        .TOKEN_TIMEOUT(TOK_TO),
        .BLOCK_BYTES  (BLK)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    // card scenario: polls before R1, R1 value, polls before token, token
    int          r1_delay = 0;
    logic [7:0]  r1_val   = 8'h00;
    int          tok_delay = 0;
    logic [7:0]  tok_val   = 8'hFE;
    logic [7:0]  blk [BLK];

    // response for the i-th byte clocked with CS low in a transaction
    function automatic logic [7:0] card_byte(int i);
        int j;
        if (i < 6) return 8'hFF;
        j = i - 6;
        if (j < r1_delay) return 8'hFF;
        if (j == r1_delay) return r1_val;
        if (r1_val != 8'h00) return 8'hFF;
        j = j - r1_delay - 1;
        if (j < tok_delay) return 8'hFF;
        if (j == tok_delay) return tok_val;
        if (tok_val != 8'hFE) return 8'hFF;
        j = j - tok_delay - 1;
        if (j < BLK) return blk[j];
        return 8'hA5;
    endfunction

    int         byte_idx = 0;
    logic [2:0] bitn = 3'd0;
    logic [7:0] resp = 8'hFF;
    logic [7:0] shin = 8'h00;
    logic [7:0] mosi_log [$];

    assign bus.miso = bus.cs ? 1'b1 : resp[~bitn];

    always @(posedge bus.sclk or posedge bus.cs) begin
        if (bus.cs) begin
            byte_idx <= 0;
            bitn     <= 3'd0;
            resp     <= card_byte(0);
        end else if (bitn == 3'd7) begin
            mosi_log.push_back({shin[6:0], bus.mosi});
            bitn     <= 3'd0;
            byte_idx <= byte_idx + 1;
            resp     <= card_byte(byte_idx + 1);
        end else begin
            shin <= {shin[6:0], bus.mosi};
            bitn <= bitn + 3'd1;
        end
    end

    int         cyc = 0;
    logic [7:0] got_q [$];
    int         got_cyc [$];
    logic       err_log [$];
    int         overlap = 0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (bus.valid) begin
            got_q.push_back(bus.data);
            got_cyc.push_back(cyc);
        end
        if (bus.done) err_log.push_back(bus.err);
        if (bus.valid && bus.done) overlap <= overlap + 1;
    end

    task automatic set_card(int r1d, logic [7:0] r1v, int tkd,
                            logic [7:0] tkv, bit seq);
        r1_delay  = r1d;
        r1_val    = r1v;
        tok_delay = tkd;
        tok_val   = tkv;
        for (int k = 0; k < BLK; k++)
            blk[k] = seq ? 8'(k) : 8'($urandom);
    endtask

    task automatic do_start(logic [31:0] a);
        @(posedge clk);
        #1 bus.start = 1'b1;
        bus.addr = a;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic wait_done(int base, int budget, string name);
        int n = 0;
        while (err_log.size() <= base && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (err_log.size() <= base) begin
            errors++;
            $display("FAIL %s_done: no done within %0d cycles",
                     name, budget);
        end
    endtask

    task automatic wait_valids(int base, int cnt, string name);
        int n = 0;
        while (got_q.size() - base < cnt && n < 20000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (got_q.size() - base < cnt) begin
            errors++;
            $display("FAIL %s_valids: got %0d, want %0d",
                     name, got_q.size() - base, cnt);
        end
    endtask

    task automatic test_reset;
        logic [14:0] got;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.addr = '0;
        repeat (2) @(posedge clk);
        #1;
        got = {bus.sclk, bus.mosi, bus.cs, bus.data,
               bus.valid, bus.busy, bus.done, bus.err};
        checks++;
        if (got !== {1'b0, 1'b1, 1'b1, 8'h00, 4'h0}) begin
            errors++;
            $display("FAIL reset_outputs: got %h, want %h",
                     got, {1'b0, 1'b1, 1'b1, 8'h00, 4'h0});
        end
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.cs !== 1'b1 || bus.sclk !== 1'b0) begin
            errors++;
            $display("FAIL idle_pins: cs=%b sclk=%b, want 1 0",
                     bus.cs, bus.sclk);
        end
    endtask

    task automatic test_happy;
        int mb, gb, db, bad, gap;
        logic [7:0] exp6 [6];
        set_card(2, 8'h00, 3, 8'hFE, 1'b1);
        mb = mosi_log.size();
        gb = got_q.size();
        db = err_log.size();
        do_start(32'h0000_1234);
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL happy_busy: got %b, want 1", bus.busy);
        end
        wait_done(db, 40000, "happy");
        exp6 = '{8'h51, 8'h00, 8'h00, 8'h12, 8'h34, 8'hFF};
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (mosi_log.size() <= mb + i ||
                mosi_log[mb + i] !== exp6[i]) begin
                errors++;
                $display("FAIL happy_cmd%0d: got %h, want %h", i,
                         mosi_log.size() > mb + i ? mosi_log[mb + i] : 8'hxx,
                         exp6[i]);
            end
        end
        checks++;
        if (mosi_log.size() - mb != 6 + 3 + 4 + BLK + 2) begin
            errors++;
            $display("FAIL happy_cs_bytes: got %0d, want %0d",
                     mosi_log.size() - mb, 6 + 3 + 4 + BLK + 2);
        end
        checks++;
        if (got_q.size() - gb != BLK) begin
            errors++;
            $display("FAIL happy_count: got %0d, want %0d",
                     got_q.size() - gb, BLK);
        end else begin
            bad = 0;
            gap = 0;
            for (int k = 0; k < BLK; k++) begin
                if (got_q[gb + k] !== 8'(k)) bad++;
                if (k > 0 && got_cyc[gb + k] - got_cyc[gb + k - 1] != BYTE_CY)
                    gap++;
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL happy_data: %0d bytes wrong, want 0", bad);
            end
            checks++;
            if (gap != 0) begin
                errors++;
                $display("FAIL happy_spacing: %0d gaps not %0d cycles",
                         gap, BYTE_CY);
            end
        end
        checks++;
        if (err_log.size() > db && err_log[db] !== 1'b0) begin
            errors++;
            $display("FAIL happy_err: got %b, want 0", err_log[db]);
        end
        checks++;
        if (bus.cs !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL happy_end: cs=%b busy=%b, want 1 0",
                     bus.cs, bus.busy);
        end
    endtask

    // expected CS-low byte count and err for an error scenario
    task automatic run_err(string name, int want_bytes);
        int mb, gb, db;
        mb = mosi_log.size();
        gb = got_q.size();
        db = err_log.size();
        do_start($urandom);
        wait_done(db, 8000, name);
        checks++;
        if (err_log.size() > db && err_log[db] !== 1'b1) begin
            errors++;
            $display("FAIL %s_err: got %b, want 1", name, err_log[db]);
        end
        checks++;
        if (got_q.size() != gb) begin
            errors++;
            $display("FAIL %s_valid: got %0d, want 0",
                     name, got_q.size() - gb);
        end
        checks++;
        if (mosi_log.size() - mb != want_bytes) begin
            errors++;
            $display("FAIL %s_bytes: got %0d, want %0d",
                     name, mosi_log.size() - mb, want_bytes);
        end
        checks++;
        if (bus.cs !== 1'b1) begin
            errors++;
            $display("FAIL %s_cs: got %b, want 1", name, bus.cs);
        end
    endtask

    task automatic test_r1_error;
        set_card(1, 8'h04, 0, 8'hFE, 1'b0);
        run_err("r1_nonzero", 6 + 2);
        set_card(1000, 8'h00, 0, 8'hFE, 1'b0);
        run_err("r1_timeout", 6 + R1_TO);
    endtask

    task automatic test_token_timeout;
        set_card(2, 8'h00, 100000, 8'hFE, 1'b0);
        run_err("tok_timeout", 6 + 3 + TOK_TO);
        set_card(0, 8'h00, 1, 8'h08, 1'b0);
        run_err("tok_error", 6 + 1 + 2);
    endtask

    task automatic test_busy_guard;
        int mb, gb, db, bad;
        logic [31:0] a, b;
        logic [7:0] e;
        set_card($urandom_range(0, 5), 8'h00, $urandom_range(0, 20),
                 8'hFE, 1'b0);
        a = $urandom;
        mb = mosi_log.size();
        gb = got_q.size();
        db = err_log.size();
        do_start(a);
        wait_valids(gb, 10, "guard");
        do_start(32'h0000_DEAD);
        wait_done(db, 40000, "guard");
        repeat (100) @(negedge clk);
        checks++;
        if (err_log.size() - db != 1) begin
            errors++;
            $display("FAIL guard_dones: got %0d, want 1",
                     err_log.size() - db);
        end
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            e = 8'(a >> (24 - 8 * i));
            if (mosi_log.size() <= mb + 1 + i ||
                mosi_log[mb + 1 + i] !== e) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL guard_addr: %0d addr bytes differ from %h",
                     bad, a);
        end
        bad = 0;
        for (int k = 0; k < BLK; k++)
            if (got_q.size() <= gb + k || got_q[gb + k] !== blk[k]) bad++;
        checks++;
        if (bad != 0 || got_q.size() - gb != BLK) begin
            errors++;
            $display("FAIL guard_data: %0d wrong of %0d, count %0d",
                     bad, BLK, got_q.size() - gb);
        end
        set_card(0, 8'h04, 0, 8'hFE, 1'b0);
        b = $urandom;
        mb = mosi_log.size();
        db = err_log.size();
        do_start(b);
        wait_done(db, 4000, "guard2");
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            e = 8'(b >> (24 - 8 * i));
            if (mosi_log.size() <= mb + 1 + i ||
                mosi_log[mb + 1 + i] !== e) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL guard2_addr: %0d addr bytes differ from %h",
                     bad, b);
        end
    endtask

    task automatic test_reset_mid;
        int mb, gb, db, bad;
        logic [3:0] got;
        set_card(1, 8'h00, 2, 8'hFE, 1'b0);
        gb = got_q.size();
        db = err_log.size();
        do_start($urandom);
        wait_valids(gb, 100, "midrst");
        rst = 1'b1;
        @(posedge clk);
        #1;
        got = {bus.cs, bus.valid, bus.done, bus.busy};
        checks++;
        if (got !== 4'b1000) begin
            errors++;
            $display("FAIL midrst_pins: cs,valid,done,busy=%b, want 1000",
                     got);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (50) @(negedge clk);
        checks++;
        if (err_log.size() != db) begin
            errors++;
            $display("FAIL midrst_nodone: got %0d dones, want 0",
                     err_log.size() - db);
        end
        set_card($urandom_range(0, 3), 8'h00, $urandom_range(0, 8),
                 8'hFE, 1'b0);
        mb = mosi_log.size();
        gb = got_q.size();
        db = err_log.size();
        do_start(32'h0BAD_F00D);
        wait_done(db, 40000, "after_rst");
        checks++;
        if (err_log.size() > db && err_log[db] !== 1'b0) begin
            errors++;
            $display("FAIL after_rst_err: got %b, want 0", err_log[db]);
        end
        checks++;
        if (mosi_log.size() <= mb + 4 || mosi_log[mb] !== 8'h51 ||
            mosi_log[mb + 4] !== 8'h0D) begin
            errors++;
            $display("FAIL after_rst_cmd: cmd/addr bytes wrong");
        end
        bad = 0;
        for (int k = 0; k < BLK; k++)
            if (got_q.size() <= gb + k || got_q[gb + k] !== blk[k]) bad++;
        checks++;
        if (bad != 0 || got_q.size() - gb != BLK) begin
            errors++;
            $display("FAIL after_rst_data: %0d wrong, count %0d",
                     bad, got_q.size() - gb);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.addr  = '0;
        test_reset();
        test_happy();
        test_r1_error();
        test_token_timeout();
        test_busy_guard();
        test_reset_mid();
        checks++;
        if (overlap != 0) begin
            errors++;
            $display("FAIL valid_done_overlap: got %0d, want 0", overlap);
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
